// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: widths, FSM states, owner codes
// and the saturating starvation-counter increment.
package vram_pkg;

    localparam int VRAM_ADDR_W = 15;
    localparam int VRAM_DATA_W = 16;
    localparam int WAIT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic OWN_VGA = 1'b0;
    localparam logic OWN_CPU = 1'b1;

    // Count one more lost arbitration, never passing the limit.
    function automatic logic [WAIT_W-1:0] wait_sat_inc(
        input logic [WAIT_W-1:0] cnt,
        input logic [WAIT_W-1:0] limit
    );
        logic [WAIT_W-1:0] res;
        if (cnt >= limit) begin
            res = limit;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vram_arb_select.sv
// Priority selection between display and CPU. The display wins ties unless
// the CPU has lost enough consecutive arbitrations to hit the starvation limit.
module vram_arb_select
    import vram_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              vga_req,
    input  logic              cpu_req,
    input  logic [WAIT_W-1:0] wait_cnt,
    output logic              grant_cpu,
    output logic              grant_any
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

    // Starved CPU first, then display, then CPU.
    always_comb begin
        grant_any = vga_req | cpu_req;
        grant_cpu = 1'b0;
        if (cpu_req && (wait_cnt == LIMIT)) begin
            grant_cpu = 1'b1;
        end else if (vga_req) begin
            grant_cpu = 1'b0;
        end else begin
            grant_cpu = cpu_req;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between the display fetch path and
// the CPU. Every access is IDLE -> ACCESS -> DONE; read data from the RAM
// arrives in DONE, where the owner receives its one-cycle completion pulse.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              we_q,        we_d;
    logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] vga_data_q,  vga_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              vga_valid_q, vga_valid_d;
    logic              cpu_ack_q,   cpu_ack_d;
    logic              busy_q,      busy_d;
    logic              grant_cpu_s, grant_any_s;
    logic              vga_done_s,  cpu_rd_done_s;

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

    vram_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .vga_req  (vga_req),
        .cpu_req  (cpu_req),
        .wait_cnt (wait_cnt_q),
        .grant_cpu(grant_cpu_s),
        .grant_any(grant_any_s)
    );

    // Next-state, latch, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        wait_cnt_d  = wait_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        vga_data_d  = vga_data_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        vga_valid_d = 1'b0;
        cpu_ack_d   = 1'b0;
        busy_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && grant_any_s) begin
                    state_d  = ST_ACCESS;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    if (grant_cpu_s) begin
                        owner_d     = OWN_CPU;
                        we_d        = cpu_we;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        wait_cnt_d  = 4'd0;
                    end else begin
                        // Display fetches never write; write data stays as it was.
                        owner_d    = OWN_VGA;
                        we_d       = 1'b0;
                        mem_addr_d = vga_addr;
                        if (cpu_req) begin
                            wait_cnt_d = wait_sat_inc(wait_cnt_q, LIMIT);
                        end else begin
                            wait_cnt_d = wait_cnt_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_DONE;
                busy_d      = 1'b1;
                vga_valid_d = (owner_q == OWN_VGA);
                cpu_ack_d   = (owner_q == OWN_CPU);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_VGA) begin
                    vga_data_d = mem_rdata;
                end else if (!we_q) begin
                    cpu_rdata_d = mem_rdata;
                end else begin
                    cpu_rdata_d = cpu_rdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset abandons any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_VGA;
            we_q        <= 1'b0;
            wait_cnt_q  <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vga_data_q  <= '0;
            cpu_rdata_q <= '0;
            vga_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vga_data_q  <= vga_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_valid_q <= vga_valid_d;
            cpu_ack_q   <= cpu_ack_d;
            busy_q      <= busy_d;
        end
    end

    // RAM data only exists during DONE, so the owner sees it there directly
    // alongside its completion pulse; afterwards the captured copy holds it.
    assign vga_done_s    = (state_q == ST_DONE) && (owner_q == OWN_VGA);
    assign cpu_rd_done_s = (state_q == ST_DONE) && (owner_q == OWN_CPU) && !we_q;
    assign vga_data      = vga_done_s    ? mem_rdata : vga_data_q;
    assign cpu_rdata     = cpu_rd_done_s ? mem_rdata : cpu_rdata_q;

    assign vga_valid = vga_valid_q;
    assign cpu_ack   = cpu_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        vga_req;
    logic [14:0] vga_addr;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    logic [15:0] ram [0:32767];

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write, one cycle latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1;
        vga_req = 1'b0; vga_addr = 15'h0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'h0; cpu_wdata = 16'h0;
        step(); step();
        checks++;
        if ({vga_data, cpu_rdata, vga_valid, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata, busy} !== 72'h0) begin
            errors++;
            $display("FAIL reset_outputs: got vd=%h cr=%h vv=%b ca=%b en=%b we=%b a=%h wd=%h busy=%b expected all 0",
                     vga_data, cpu_rdata, vga_valid, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata, busy);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 16'hBEEF;
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, busy} !== {1'b1, 1'b1, 15'h0010, 16'hBEEF, 1'b1}) begin
            errors++;
            $display("FAIL wr_access: got en=%b we=%b a=%h wd=%h busy=%b expected 1 1 0010 beef 1",
                     mem_en, mem_we, mem_addr, mem_wdata, busy);
        end
        step();
        checks++;
        if ({cpu_ack, vga_valid, mem_en, mem_we} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wr_done: got ack=%b vv=%b en=%b we=%b expected 1 0 0 0", cpu_ack, vga_valid, mem_en, mem_we);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        checks++;
        if ({cpu_ack, busy, mem_addr} !== {1'b0, 1'b0, 15'h0010}) begin
            errors++;
            $display("FAIL wr_idle: got ack=%b busy=%b a=%h expected 0 0 0010", cpu_ack, busy, mem_addr);
        end
    endtask

    task automatic test_vga_read();
        vga_req = 1'b1; vga_addr = 15'h0010;
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr, vga_valid} !== {1'b1, 1'b0, 15'h0010, 1'b0}) begin
            errors++;
            $display("FAIL rd_access: got en=%b we=%b a=%h vv=%b expected 1 0 0010 0", mem_en, mem_we, mem_addr, vga_valid);
        end
        step();
        checks++;
        if ({vga_valid, vga_data, mem_we, cpu_ack} !== {1'b1, 16'hBEEF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rd_done: got vv=%b vd=%h we=%b ack=%b expected 1 beef 0 0", vga_valid, vga_data, mem_we, cpu_ack);
        end
        vga_req = 1'b0;
        step();
        checks++;
        if ({vga_valid, vga_data} !== {1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL rd_hold: got vv=%b vd=%h expected 0 beef", vga_valid, vga_data);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] pattern;
        logic       exp_cpu;
        pattern  = 10'b1000010000; // bit i set: grant i goes to the CPU
        vga_req  = 1'b1; vga_addr = 15'h0020;
        cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0001;
        for (int g = 0; g < 10; g++) begin
            exp_cpu = pattern[g];
            step();
            checks++;
            if ({mem_en, mem_addr} !== {1'b1, (exp_cpu ? 15'h0001 : 15'h0020)}) begin
                errors++;
                $display("FAIL starve_grant%0d: got en=%b a=%h expected 1 %h",
                         g, mem_en, mem_addr, (exp_cpu ? 15'h0001 : 15'h0020));
            end
            step();
            checks++;
            if ({vga_valid, cpu_ack} !== {~exp_cpu, exp_cpu}) begin
                errors++;
                $display("FAIL starve_done%0d: got vv=%b ack=%b expected %b %b", g, vga_valid, cpu_ack, ~exp_cpu, exp_cpu);
            end
            if (exp_cpu) begin
                checks++;
                if (cpu_rdata !== 16'h0BAD) begin
                    errors++;
                    $display("FAIL starve_rdata%0d: got %h expected 0bad", g, cpu_rdata);
                end
            end
            if (g == 9) begin
                vga_req = 1'b0; cpu_req = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset_mid_access();
        logic saw_ack;
        saw_ack = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0030; cpu_wdata = 16'hA5A5;
        step();
        checks++;
        if ({mem_en, mem_we} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre: got en=%b we=%b expected 1 1", mem_en, mem_we);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, busy, mem_addr} !== {1'b0, 1'b0, 1'b0, 15'h0}) begin
            errors++;
            $display("FAIL rst_immediate: got en=%b we=%b busy=%b a=%h expected 0 0 0 0000", mem_en, mem_we, busy, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpu_ack) saw_ack = 1'b1;
        end
        reset = 1'b1;
        if (cpu_ack) saw_ack = 1'b1;
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 15'h0030, 16'hA5A5}) begin
            errors++;
            $display("FAIL rst_reissue_access: got en=%b we=%b a=%h wd=%h expected 1 1 0030 a5a5",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (saw_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_ack: got ack seen=%b expected 0", saw_ack);
        end
        step();
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL rst_reissue_ack: got %b expected 1", cpu_ack);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
    endtask

    task automatic test_enable();
        int stray;
        stray   = 0;
        vga_req = 1'b1; vga_addr = 15'h0020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0040;
        step();
        enable = 1'b0;
        step();
        checks++;
        if ({vga_valid, vga_data, cpu_ack} !== {1'b1, 16'h5A5A, 1'b0}) begin
            errors++;
            $display("FAIL en_complete: got vv=%b vd=%h ack=%b expected 1 5a5a 0", vga_valid, vga_data, cpu_ack);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            if (mem_en || busy) stray++;
            step();
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL en_hold: got %0d cycles with mem_en/busy expected 0", stray);
        end
        enable = 1'b1;
        step();
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 15'h0020}) begin
            errors++;
            $display("FAIL en_resume: got en=%b a=%h expected 1 0020", mem_en, mem_addr);
        end
        step();
        vga_req = 1'b0; cpu_req = 1'b0;
        step();
    endtask

    task automatic test_max_addr();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h7FFF;
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 15'h7FFF}) begin
            errors++;
            $display("FAIL max_access: got en=%b we=%b a=%h expected 1 0 7fff", mem_en, mem_we, mem_addr);
        end
        step();
        checks++;
        if ({cpu_ack, cpu_rdata, vga_data, vga_valid} !== {1'b1, 16'h1234, 16'h5A5A, 1'b0}) begin
            errors++;
            $display("FAIL max_done: got ack=%b cr=%h vd=%h vv=%b expected 1 1234 5a5a 0", cpu_ack, cpu_rdata, vga_data, vga_valid);
        end
        cpu_req = 1'b0;
        step();
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL max_hold: got ack=%b cr=%h expected 0 1234", cpu_ack, cpu_rdata);
        end
    endtask

    initial begin
        ram[15'h0001] = 16'h0BAD;
        ram[15'h0010] = 16'h0000;
        ram[15'h0020] = 16'h5A5A;
        ram[15'h0030] = 16'h0000;
        ram[15'h0040] = 16'h4040;
        ram[15'h7FFF] = 16'h1234;
        mem_rdata     = 16'h0000;
        test_reset();
        test_cpu_write();
        test_vga_read();
        test_starvation();
        test_reset_mid_access();
        test_enable();
        test_max_addr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
